iod_ref_clk_training_ctrl: RTL and testbench

//  Multi-lane delay-line training controller for PolarFire IOD receive lanes in the DDR3 PHY.

---
 rtl/iod_train_pkg.sv | 26 ++
 rtl/iod_eye_window_tracker.sv | 77 +++++++
 rtl/iod_ref_clk_training_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_iod_ref_clk_training_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iod_train_pkg.sv
// Shared state encoding, parameter defaults and lane-slice helper for the
// IOD reference-clock delay-line training controller.
package iod_train_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_SETTLE,
        ST_SAMPLE,
        ST_STEP,
        ST_CENTER,
        ST_BACK,
        ST_FAIL,
        ST_NEXT,
        ST_DONE
    } train_state_t;

    localparam int DEFAULT_TAP_BITS     = 8;
    localparam int DEFAULT_MIN_EYE_TAPS = 4;

    function automatic int lane_lsb(input int lane, input int tap_bits);
        return lane * tap_bits;
    endfunction

endpackage

// File: rtl/iod_eye_window_tracker.sv
// Tracks the tap position and the open-eye run (start, end, length) of one
// delay-line sweep; flags a usable eye or an exhausted sweep during SAMPLE.
module iod_eye_window_tracker
    import iod_train_pkg::*;
#(
    parameter int TAP_BITS     = DEFAULT_TAP_BITS,
    parameter int MAX_TAPS     = 128,
    parameter int MIN_EYE_TAPS = DEFAULT_MIN_EYE_TAPS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                sample,
    input  logic                open,
    input  logic                step_up,
    input  logic                step_down,
    output logic [TAP_BITS-1:0] tap,
    output logic [TAP_BITS-1:0] center,
    output logic                eye_found,
    output logic                eye_fail
);

    localparam int RUN_BITS = TAP_BITS + 1;
    localparam logic [TAP_BITS-1:0] LAST_TAP = TAP_BITS'(MAX_TAPS - 1);
    localparam logic [RUN_BITS-1:0] MIN_RUN  = RUN_BITS'(MIN_EYE_TAPS);

    logic [TAP_BITS-1:0] eye_start;
    logic [TAP_BITS-1:0] eye_end;
    logic [RUN_BITS-1:0] run;
    logic [RUN_BITS-1:0] run_next;
    logic [TAP_BITS:0]   eye_sum;
    logic                at_last;

    // A closed tap after a wide enough run keeps the run so the eye survives into CENTER.
    always_comb begin
        run_next = run;
        if (open) begin
            if (run != '1) run_next = run + 1'b1;
        end else if (run < MIN_RUN) begin
            run_next = '0;
        end
    end

    assign at_last   = (tap == LAST_TAP);
    assign eye_found = sample && ((!open && (run >= MIN_RUN)) || (at_last && (run_next >= MIN_RUN)));
    assign eye_fail  = sample && at_last && !eye_found;
    assign eye_sum   = {1'b0, eye_start} + {1'b0, eye_end};
    assign center    = eye_sum[TAP_BITS:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap       <= '0;
            eye_start <= '0;
            eye_end   <= '0;
            run       <= '0;
        end else if (clear) begin
            tap       <= '0;
            eye_start <= '0;
            eye_end   <= '0;
            run       <= '0;
        end else begin
            if (sample) begin
                run <= run_next;
                if (open) begin
                    if (run == '0) eye_start <= tap;
                    eye_end <= tap;
                end
            end
            if (step_up) begin
                tap <= tap + 1'b1;
            end else if (step_down) begin
                tap <= tap - 1'b1;
            end
        end
    end

endmodule

// File: rtl/iod_ref_clk_training_ctrl.sv
// Multi-lane IOD RX delay-line training: sweeps each lane, finds the open eye
// from the early/late monitor flags and parks the delay line at its centre.
module iod_ref_clk_training_ctrl
    import iod_train_pkg::*;
#(
    parameter int NUM_LANES     = 1,
    parameter int TAP_BITS      = DEFAULT_TAP_BITS,
    parameter int MAX_TAPS      = 128,
    parameter int SETTLE_CYCLES = 8,
    parameter int MIN_EYE_TAPS  = DEFAULT_MIN_EYE_TAPS
) (
    input  logic                          FAB_CLK,
    input  logic                          ARST_N,
    input  logic                          TRAIN_START,
    output logic                          TRAIN_BUSY,
    output logic                          TRAIN_DONE,
    output logic                          TRAIN_ERR,
    output logic [NUM_LANES-1:0]          LANE_ERR,
    output logic [NUM_LANES*TAP_BITS-1:0] LANE_TAP,
    output logic [NUM_LANES-1:0]          DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]          DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]          DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0]          EYE_MONITOR_CLEAR_FLAGS,
    input  logic [NUM_LANES-1:0]          EYE_MONITOR_EARLY,
    input  logic [NUM_LANES-1:0]          EYE_MONITOR_LATE,
    input  logic [NUM_LANES-1:0]          DELAY_LINE_OUT_OF_RANGE
);

    localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    train_state_t        state;
    logic [LANE_W-1:0]   lane;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                back_phase;
    logic                lane_failed;
    logic [NUM_LANES-1:0] lane_mask;
    logic [TAP_BITS-1:0] tap;
    logic [TAP_BITS-1:0] center;
    logic                eye_found;
    logic                eye_fail;
    logic                lane_open;
    logic                lane_oor;
    logic                trk_clear;
    logic                trk_sample;
    logic                trk_up;
    logic                trk_down;

    assign lane_mask  = NUM_LANES'(1) << lane;
    assign lane_open  = !EYE_MONITOR_EARLY[lane] && !EYE_MONITOR_LATE[lane];
    assign lane_oor   = DELAY_LINE_OUT_OF_RANGE[lane];
    assign trk_clear  = (state == ST_LOAD);
    assign trk_sample = (state == ST_SAMPLE) && !lane_oor;
    assign trk_up     = (state == ST_STEP) && !lane_oor;
    assign trk_down   = (state == ST_BACK) && back_phase && (tap > center) && !lane_oor;
    assign TRAIN_ERR  = |LANE_ERR;

    iod_eye_window_tracker #(
        .TAP_BITS     (TAP_BITS),
        .MAX_TAPS     (MAX_TAPS),
        .MIN_EYE_TAPS (MIN_EYE_TAPS)
    ) u_tracker (
        .clk       (FAB_CLK),
        .rst_n     (ARST_N),
        .clear     (trk_clear),
        .sample    (trk_sample),
        .open      (lane_open),
        .step_up   (trk_up),
        .step_down (trk_down),
        .tap       (tap),
        .center    (center),
        .eye_found (eye_found),
        .eye_fail  (eye_fail)
    );

    // Walking back to the centre alternates a direction-setup cycle and a MOVE cycle.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state                   <= ST_IDLE;
            lane                    <= '0;
            settle_cnt              <= '0;
            back_phase              <= 1'b0;
            lane_failed             <= 1'b0;
            TRAIN_BUSY              <= 1'b0;
            TRAIN_DONE              <= 1'b0;
            LANE_ERR                <= '0;
            LANE_TAP                <= '0;
            DELAY_LINE_LOAD         <= '0;
            DELAY_LINE_MOVE         <= '0;
            DELAY_LINE_DIRECTION    <= '1;
            EYE_MONITOR_CLEAR_FLAGS <= '0;
        end else begin
            DELAY_LINE_LOAD         <= '0;
            DELAY_LINE_MOVE         <= '0;
            EYE_MONITOR_CLEAR_FLAGS <= '0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (TRAIN_START) begin
                        lane       <= '0;
                        TRAIN_DONE <= 1'b0;
                        TRAIN_BUSY <= 1'b1;
                        LANE_ERR   <= '0;
                        LANE_TAP   <= '0;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    DELAY_LINE_LOAD <= lane_mask;
                    lane_failed     <= 1'b0;
                    state           <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    EYE_MONITOR_CLEAR_FLAGS <= lane_mask;
                    settle_cnt              <= SETTLE_W'(SETTLE_CYCLES - 1);
                    state                   <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (lane_oor || eye_fail) begin
                        state <= ST_FAIL;
                    end else if (eye_found) begin
                        state <= ST_CENTER;
                    end else begin
                        state <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (lane_oor) begin
                        state <= ST_FAIL;
                    end else begin
                        DELAY_LINE_DIRECTION[lane] <= 1'b1;
                        DELAY_LINE_MOVE            <= lane_mask;
                        state                      <= ST_CLEAR;
                    end
                end
                ST_CENTER: begin
                    back_phase <= 1'b0;
                    state      <= ST_BACK;
                end
                ST_BACK: begin
                    if (lane_oor) begin
                        state <= ST_FAIL;
                    end else if (tap == center) begin
                        state <= ST_NEXT;
                    end else if (!back_phase) begin
                        DELAY_LINE_DIRECTION[lane] <= 1'b0;
                        back_phase                 <= 1'b1;
                    end else begin
                        DELAY_LINE_MOVE <= lane_mask;
                        back_phase      <= 1'b0;
                    end
                end
                ST_FAIL: begin
                    LANE_ERR[lane]                                     <= 1'b1;
                    LANE_TAP[lane_lsb(int'(lane), TAP_BITS) +: TAP_BITS] <= '0;
                    lane_failed                                        <= 1'b1;
                    state                                              <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (!lane_failed) begin
                        LANE_TAP[lane_lsb(int'(lane), TAP_BITS) +: TAP_BITS] <= tap;
                    end
                    if (lane == LAST_LANE) begin
                        TRAIN_BUSY <= 1'b0;
                        TRAIN_DONE <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        lane  <= lane + 1'b1;
                        state <= ST_LOAD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iod_ref_clk_training_ctrl.sv
// Scoreboard bench for the IOD training controller: a behavioural IOD model
// provides eye windows and out-of-range, and counts delay-line strobes per lane.
module tb_iod_ref_clk_training_ctrl;

    localparam int NL = 2;
    localparam int TB = 8;
    localparam int MT = 32;
    localparam int SC = 4;
    localparam int ME = 4;

    logic             clk     = 1'b0;
    logic             arst_n  = 1'b0;
    logic             start   = 1'b0;
    logic             busy;
    logic             done;
    logic             train_err;
    logic [NL-1:0]    lane_err;
    logic [NL*TB-1:0] lane_tap;
    logic [NL-1:0]    dl_load;
    logic [NL-1:0]    dl_move;
    logic [NL-1:0]    dl_dir;
    logic [NL-1:0]    clear_flags;
    logic [NL-1:0]    early;
    logic [NL-1:0]    late;
    logic [NL-1:0]    oor;

    typedef struct {
        logic [NL-1:0]    err;
        logic [NL*TB-1:0] taps;
        int               ups0;
        int               downs0;
        int               ups1;
        int               downs1;
    } expect_t;

    expect_t exp_q[$];

    int model_tap [NL];
    int win_lo    [NL];
    int win_hi    [NL];
    int nar_lo    [NL];
    int nar_hi    [NL];
    int oor_tap   [NL];
    int ups       [NL];
    int downs     [NL];
    int loads     [NL];
    int clears    [NL];
    int base_ups   [NL];
    int base_downs [NL];
    int base_loads [NL];
    int base_clrs  [NL];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iod_ref_clk_training_ctrl #(
        .NUM_LANES     (NL),
        .TAP_BITS      (TB),
        .MAX_TAPS      (MT),
        .SETTLE_CYCLES (SC),
        .MIN_EYE_TAPS  (ME)
    ) dut (
        .FAB_CLK                 (clk),
        .ARST_N                  (arst_n),
        .TRAIN_START             (start),
        .TRAIN_BUSY              (busy),
        .TRAIN_DONE              (done),
        .TRAIN_ERR               (train_err),
        .LANE_ERR                (lane_err),
        .LANE_TAP                (lane_tap),
        .DELAY_LINE_LOAD         (dl_load),
        .DELAY_LINE_MOVE         (dl_move),
        .DELAY_LINE_DIRECTION    (dl_dir),
        .EYE_MONITOR_CLEAR_FLAGS (clear_flags),
        .EYE_MONITOR_EARLY       (early),
        .EYE_MONITOR_LATE        (late),
        .DELAY_LINE_OUT_OF_RANGE (oor)
    );

    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (clear_flags[i]) clears[i] <= clears[i] + 1;
            if (dl_load[i]) begin
                model_tap[i] <= 0;
                loads[i]     <= loads[i] + 1;
            end else if (dl_move[i]) begin
                if (dl_dir[i]) begin
                    model_tap[i] <= model_tap[i] + 1;
                    ups[i]       <= ups[i] + 1;
                end else begin
                    model_tap[i] <= model_tap[i] - 1;
                    downs[i]     <= downs[i] + 1;
                end
            end
        end
    end

    always_comb begin
        early = '0;
        late  = '0;
        oor   = '0;
        for (int i = 0; i < NL; i++) begin
            logic is_open;
            is_open = ((model_tap[i] >= win_lo[i]) && (model_tap[i] <= win_hi[i])) ||
                      ((model_tap[i] >= nar_lo[i]) && (model_tap[i] <= nar_hi[i]));
            early[i] = !is_open;
            late[i]  = !is_open;
            oor[i]   = (model_tap[i] == oor_tap[i]);
        end
    end

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic set_lane(input int i, input int lo, input int hi, input int nlo, input int nhi, input int ot);
        win_lo[i]  = lo;
        win_hi[i]  = hi;
        nar_lo[i]  = nlo;
        nar_hi[i]  = nhi;
        oor_tap[i] = ot;
    endtask

    task automatic start_training();
        for (int i = 0; i < NL; i++) begin
            base_ups[i]   = ups[i];
            base_downs[i] = downs[i];
            base_loads[i] = loads[i];
            base_clrs[i]  = clears[i];
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic apply_stimulus(input expect_t e);
        exp_q.push_back(e);
        start_training();
    endtask

    task automatic wait_done_and_check(input string name);
        int n;
        expect_t e;
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_output({name, "_done"}, 64'(done), 64'd1);
        if (exp_q.size() == 0) begin
            check_output({name, "_queue"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check_output({name, "_busy"},    64'(busy),           64'd0);
            check_output({name, "_tap0"},    64'(lane_tap[7:0]),  64'(e.taps[7:0]));
            check_output({name, "_tap1"},    64'(lane_tap[15:8]), 64'(e.taps[15:8]));
            check_output({name, "_lane_err"}, 64'(lane_err),      64'(e.err));
            check_output({name, "_train_err"}, 64'(train_err),    64'(|e.err));
            check_output({name, "_ups0"},   64'(ups[0] - base_ups[0]),     64'(e.ups0));
            check_output({name, "_downs0"}, 64'(downs[0] - base_downs[0]), 64'(e.downs0));
            check_output({name, "_ups1"},   64'(ups[1] - base_ups[1]),     64'(e.ups1));
            check_output({name, "_downs1"}, 64'(downs[1] - base_downs[1]), 64'(e.downs1));
            check_output({name, "_loads0"}, 64'(loads[0] - base_loads[0]), 64'd1);
            check_output({name, "_loads1"}, 64'(loads[1] - base_loads[1]), 64'd1);
            check_output({name, "_clears0"}, 64'(clears[0] - base_clrs[0]), 64'(e.ups0 + 1));
            check_output({name, "_clears1"}, 64'(clears[1] - base_clrs[1]), 64'(e.ups1 + 1));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check_output({name, "_busy"},  64'(busy),        64'd0);
        check_output({name, "_done"},  64'(done),        64'd0);
        check_output({name, "_err"},   64'(lane_err),    64'd0);
        check_output({name, "_tap"},   64'(lane_tap),    64'd0);
        check_output({name, "_load"},  64'(dl_load),     64'd0);
        check_output({name, "_move"},  64'(dl_move),     64'd0);
        check_output({name, "_clear"}, 64'(clear_flags), 64'd0);
        check_output({name, "_dir"},   64'(dl_dir),      64'h3);
    endtask

    initial begin
        expect_t e;
        int n;

        for (int i = 0; i < NL; i++) set_lane(i, 1, 0, 1, 0, -1);
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Lane 0 eye 10..20, lane 1 eye spans the whole sweep.
        set_lane(0, 10, 20, 1, 0, -1);
        set_lane(1, 0, 31, 1, 0, -1);
        e = '{err: 2'b00, taps: {8'd15, 8'd15}, ups0: 21, downs0: 6, ups1: 31, downs1: 16};
        apply_stimulus(e);
        check_output("a_busy_after_start", 64'(busy), 64'd1);
        wait_done_and_check("a");

        // Narrow pulse rejected before a real eye; lane 1 never opens.
        set_lane(0, 8, 13, 3, 4, -1);
        set_lane(1, 1, 0, 1, 0, -1);
        e = '{err: 2'b10, taps: {8'd0, 8'd10}, ups0: 14, downs0: 4, ups1: 31, downs1: 0};
        apply_stimulus(e);
        wait_done_and_check("b");

        // Out-of-range on lane 0 at tap 7, plus a start pulse while busy.
        set_lane(0, 0, 31, 1, 0, 7);
        set_lane(1, 5, 12, 1, 0, -1);
        e = '{err: 2'b01, taps: {8'd8, 8'd0}, ups0: 7, downs0: 0, ups1: 13, downs1: 5};
        apply_stimulus(e);
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("c_busy_ignored_start", 64'(busy), 64'd1);
        wait_done_and_check("c");

        // Restart from DONE clears the previous results.
        set_lane(0, 10, 20, 1, 0, -1);
        set_lane(1, 0, 31, 1, 0, -1);
        e = '{err: 2'b00, taps: {8'd15, 8'd15}, ups0: 21, downs0: 6, ups1: 31, downs1: 16};
        apply_stimulus(e);
        check_output("d_restart_err",  64'(lane_err), 64'd0);
        check_output("d_restart_tap",  64'(lane_tap), 64'd0);
        check_output("d_restart_done", 64'(done),     64'd0);
        wait_done_and_check("d");

        // Async reset while lane 0 walks back to the centre.
        start_training();
        n = 0;
        while ((downs[0] == base_downs[0]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_output("e_reached_back", 64'(n < 2000), 64'd1);
        #2;
        arst_n = 1'b0;
        #1;
        check_reset_outputs("e_async");
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(e);
        @(negedge clk);
        check_output("e_first_load", 64'(dl_load), 64'h1);
        wait_done_and_check("e");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
